life_window_gen: RTL and testbench
==================================

# life_window_gen

Streaming neighbourhood generator for the Game of Life datapath: accepts one grid frame as a row-major stream of cell bits and emits, for every cell, its own state plus its 8 neighbour states in the exact self/neighbors form consumed by the per-cell rule evaluator. It sits between the frame source (memory or serial loader) and the cell-rule logic, and replaces hard-wiring a full WIDTH×HEIGHT array of evaluators with one time-multiplexed evaluator.

## Interface
- WIDTH, 8, grid columns; must be ≥2
- HEIGHT, 8, grid rows; must be ≥2
- clk  input  1  clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  in_cell is valid
- in_ready  output  1  block accepts in_cell this cycle
- in_cell  input  1  next cell of the frame, row-major order, (0,0) first
- out_valid  output  1  output window valid
- out_ready  input  1  consumer accepts window this cycle
- out_self  output  1  centre cell state
- out_neighbors  output  8  bit0 NW, 1 N, 2 NE, 3 W, 4 E, 5 SW, 6 S, 7 SE
- out_last  output  1  window is for cell (HEIGHT-1, WIDTH-1)
- out_next  output  1  next-generation state (only with LIFE_NEXT_EN)

## Operation
- Storage: shift register SR of 2·WIDTH+3 bits; SR[0] = newest cell. Centre = SR[WIDTH+1]. Taps: SE=SR[0], S=SR[1], SW=SR[2], E=SR[WIDTH], W=SR[WIDTH+2], NE=SR[2·WIDTH], N=SR[2·WIDTH+1], NW=SR[2·WIDTH+2].
- Centre row/column counters (r,c) mask neighbours outside the grid to 0: r==0 → NW,N,NE; r==HEIGHT-1 → SW,S,SE; c==0 → NW,W,SW; c==WIDTH-1 → NE,E,SE. No wrap-around.
- Lag L = WIDTH+1 cells. FSM:
  - FILL: accept cells, shift SR, emit nothing; after L accepts → RUN.
  - RUN: each accept shifts SR and loads one window into the output register; after cell WIDTH·HEIGHT-1 accepted → DRAIN.
  - DRAIN: in_ready=0; each free output slot shifts a 0 into SR and loads one window; after L windows → FILL (next frame), counters cleared.
- Exactly WIDTH·HEIGHT windows per frame, in row-major centre order; out_last on the final one only.
- Output register: a single slot; loaded only when empty or being consumed (out_valid=0 or out_ready=1). Contents and out_valid hold while out_valid=1 and out_ready=0.
- in_ready = (state≠DRAIN) and (out_valid=0 or out_ready=1). In FILL the same rule applies, for uniform handshake.
- Frame boundary: the next frame's first cell is accepted only after DRAIN completes; SR contents from the previous frame never reach an unmasked tap.
- Reset: state=FILL, counters=0, SR=0, out_valid=0, out_self=0, out_neighbors=0, out_last=0, out_next=0. Reset mid-frame discards all partial frame data; the next accepted cell is (0,0).

## Timing
- Handshake transfer on rising edge when valid and ready are both 1.
- Latency: window for centre (r,c) is registered on the edge that accepts cell index r·WIDTH+c+L (RUN) → out_valid the following cycle; in DRAIN one window per cycle while out_ready=1.
- Full throughput: one cell in / one window out per cycle with out_ready held high; no bubbles at RUN/DRAIN or DRAIN/FILL transitions except FILL itself (L cycles of no output per frame).
- Simultaneous out_ready and load: old window consumed and new one loaded on the same edge.

## Configuration
- LIFE_NEXT_EN defined: out_next port present, registered with the window; out_next = 1 iff popcount(out_neighbors)==3, or out_self==1 and popcount==2. Popcount is 4 bits, range 0..8.
- LIFE_NEXT_EN undefined: out_next port and popcount logic absent; all other behaviour identical.

## Test plan
- 4×4, all zeros, out_ready=1 → 16 windows, all out_self=0, out_neighbors=8'h00, out_last only on 16th; first out_valid one cycle after the 6th accept.
- 4×4, single live cell at (1,1) → (1,1): self=1, nbrs 8'h00; (0,0): 8'h80; (0,1): 8'h40; (0,2): 8'h20; (1,0): 8'h10; (1,2): 8'h08; (2,0): 8'h04; (2,1): 8'h02; (2,2): 8'h01; all others 8'h00.
- 4×4, all ones → (0,0): 8'hD0; (0,1): 8'hF8; (3,3): 8'h0B; (1,1): 8'hFF.
- Two back-to-back frames with out_ready low for 5 cycles mid-RUN and mid-DRAIN → in_ready=0 and outputs stable while stalled; both frames' window sequences identical to the unstalled run, no loss or duplication.
- rst pulsed after 7 accepts, then a full 4×4 single-cell frame → output identical to the clean single-cell case.
- LIFE_NEXT_EN, 4×4, horizontal blinker at (1,0),(1,1),(1,2) → out_next=1 only at (0,1),(1,1),(2,1); 0 elsewhere.

Source files
------------

// File: rtl/life_window_gen_if.sv
// Handshake bundle for life_window_gen: cell stream in, neighbourhood windows out.
// Carries out_next only when LIFE_NEXT_EN is defined.
interface life_window_gen_if;
    logic       in_valid;
    logic       in_ready;
    logic       in_cell;
    logic       out_valid;
    logic       out_ready;
    logic       out_self;
    logic [7:0] out_neighbors;
    logic       out_last;
`ifdef LIFE_NEXT_EN
    logic       out_next;

    modport master (
        output in_valid, in_cell, out_ready,
        input  in_ready, out_valid, out_self, out_neighbors, out_last, out_next
    );

    modport slave (
        input  in_valid, in_cell, out_ready,
        output in_ready, out_valid, out_self, out_neighbors, out_last, out_next
    );
`else
    modport master (
        output in_valid, in_cell, out_ready,
        input  in_ready, out_valid, out_self, out_neighbors, out_last
    );

    modport slave (
        input  in_valid, in_cell, out_ready,
        output in_ready, out_valid, out_self, out_neighbors, out_last
    );
`endif
endinterface

// File: rtl/life_window_gen.sv
// Streaming 3x3 neighbourhood generator: row-major cell stream in, one masked window per cell out.
// Define LIFE_NEXT_EN to add the registered next-generation output out_next.
module life_window_gen #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned HEIGHT = 8
) (
    input logic                clk,
    input logic                rst,
    life_window_gen_if.slave   io_bus
);
    localparam int unsigned SrLen  = 2 * WIDTH + 3;
    localparam int unsigned Lag    = WIDTH + 1;
    localparam int unsigned NCells = WIDTH * HEIGHT;
    localparam int unsigned CntW   = $clog2(NCells);
    localparam int unsigned ColW   = $clog2(WIDTH);
    localparam int unsigned RowW   = $clog2(HEIGHT);

    typedef enum logic [1:0] {StFill, StRun, StDrain} state_e;

    state_e            r_state;
    logic [SrLen-1:0]  r_sr;
    logic [CntW-1:0]   r_in_cnt;
    logic [RowW-1:0]   r_row;
    logic [ColW-1:0]   r_col;
    logic              r_out_valid;
    logic              r_out_self;
    logic [7:0]        r_out_nbrs;
    logic              r_out_last;

    logic              w_slot_free;
    logic              w_in_ready;
    logic              w_in_fire;
    logic              w_shift;
    logic              w_load;
    logic [SrLen-1:0]  w_sr_next;
    logic              w_top;
    logic              w_bot;
    logic              w_lft;
    logic              w_rgt;
    logic              w_self;
    logic [7:0]        w_nbrs;

    always_comb begin
        w_slot_free = !r_out_valid || io_bus.out_ready;
        w_in_ready  = (r_state != StDrain) && w_slot_free;
        w_in_fire   = w_in_ready && io_bus.in_valid;
        w_shift     = w_in_fire || ((r_state == StDrain) && w_slot_free);
        w_load      = w_shift && (r_state != StFill);
        // Drain pushes zeros so the final row's windows can still be formed
        w_sr_next   = {r_sr[SrLen-2:0], (r_state == StDrain) ? 1'b0 : io_bus.in_cell};

        w_top = (r_row == '0);
        w_bot = (r_row == RowW'(HEIGHT - 1));
        w_lft = (r_col == '0);
        w_rgt = (r_col == ColW'(WIDTH - 1));

        w_self    = w_sr_next[WIDTH+1];
        w_nbrs[0] = w_sr_next[2*WIDTH+2] & ~w_top & ~w_lft;
        w_nbrs[1] = w_sr_next[2*WIDTH+1] & ~w_top;
        w_nbrs[2] = w_sr_next[2*WIDTH]   & ~w_top & ~w_rgt;
        w_nbrs[3] = w_sr_next[WIDTH+2]   & ~w_lft;
        w_nbrs[4] = w_sr_next[WIDTH]     & ~w_rgt;
        w_nbrs[5] = w_sr_next[2]         & ~w_bot & ~w_lft;
        w_nbrs[6] = w_sr_next[1]         & ~w_bot;
        w_nbrs[7] = w_sr_next[0]         & ~w_bot & ~w_rgt;
    end

`ifdef LIFE_NEXT_EN
    logic [3:0] w_pop;
    logic       w_next;
    logic       r_out_next;

    always_comb begin
        w_pop = '0;
        for (int i = 0; i < 8; i++) begin
            w_pop = w_pop + {3'b000, w_nbrs[i]};
        end
        w_next = (w_pop == 4'd3) || (w_self && (w_pop == 4'd2));
    end

    assign io_bus.out_next = r_out_next;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= StFill;
            r_sr        <= '0;
            r_in_cnt    <= '0;
            r_row       <= '0;
            r_col       <= '0;
            r_out_valid <= 1'b0;
            r_out_self  <= 1'b0;
            r_out_nbrs  <= '0;
            r_out_last  <= 1'b0;
`ifdef LIFE_NEXT_EN
            r_out_next  <= 1'b0;
`endif
        end else begin
            if (w_shift) begin
                r_sr <= w_sr_next;
            end

            if (w_load) begin
                r_out_valid <= 1'b1;
                r_out_self  <= w_self;
                r_out_nbrs  <= w_nbrs;
                r_out_last  <= w_bot && w_rgt;
`ifdef LIFE_NEXT_EN
                r_out_next  <= w_next;
`endif
                // Centre counters wrap to (0,0) on the final window of the frame
                if (w_rgt) begin
                    r_col <= '0;
                    r_row <= w_bot ? '0 : r_row + RowW'(1);
                end else begin
                    r_col <= r_col + ColW'(1);
                end
            end else if (io_bus.out_ready) begin
                r_out_valid <= 1'b0;
            end

            unique case (r_state)
                StFill: begin
                    if (w_in_fire) begin
                        r_in_cnt <= r_in_cnt + CntW'(1);
                        if (r_in_cnt == CntW'(Lag - 1)) begin
                            r_state <= StRun;
                        end
                    end
                end
                StRun: begin
                    if (w_in_fire) begin
                        if (r_in_cnt == CntW'(NCells - 1)) begin
                            r_in_cnt <= '0;
                            r_state  <= StDrain;
                        end else begin
                            r_in_cnt <= r_in_cnt + CntW'(1);
                        end
                    end
                end
                StDrain: begin
                    if (w_load && w_bot && w_rgt) begin
                        r_state <= StFill;
                    end
                end
                default: r_state <= StFill;
            endcase
        end
    end

    assign io_bus.in_ready      = w_in_ready;
    assign io_bus.out_valid     = r_out_valid;
    assign io_bus.out_self      = r_out_self;
    assign io_bus.out_neighbors = r_out_nbrs;
    assign io_bus.out_last      = r_out_last;

endmodule

// File: tb/tb_life_window_gen.sv
// Self-checking bench for life_window_gen (4x4): grid-level reference model plus literal pins.
module tb_life_window_gen;
    localparam int W = 4;
    localparam int H = 4;
    localparam int N = W * H;

    typedef struct {
        int         idx;
        logic       self;
        logic [7:0] nbrs;
        logic       last;
        logic       nxt;
    } win_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    life_window_gen_if bus ();

    life_window_gen #(.WIDTH(W), .HEIGHT(H)) dut (
        .clk    (clk),
        .rst    (rst),
        .io_bus (bus)
    );

    win_t       exp_q[$];
    int         n_cmp = 0;
    int         n_err = 0;
    bit         chk_en = 1'b1;
    bit         t_arm = 1'b0;
    int         ready_mode = 0;
    int         stall_cnt = 0;
    int         cyc = 0;
    int         acc_total = 0;
    bit         fire_pend = 1'b0;
    int         first_acc = -1;
    int         first_cyc = 0;
    int         last_cyc = 0;
    int         tot_win = 0;
    bit         prev_stall = 1'b0;
    logic       held_self;
    logic [7:0] held_nbrs;
    logic       held_last;
    logic       cap_self[N];
    logic [7:0] cap_nbrs[N];
    logic       cap_next[N];

    task automatic check(input string name, input int got, input int expv);
        n_cmp++;
        if (got != expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, expv);
        end
    endtask

    // Expected windows straight from the grid: neighbours by coordinates, off-grid reads as 0.
    function automatic void model_frame(input logic [N-1:0] f);
        int dr[8] = '{-1, -1, -1, 0, 0, 1, 1, 1};
        int dc[8] = '{-1, 0, 1, -1, 1, -1, 0, 1};
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                win_t w;
                int   pop;
                pop    = 0;
                w.idx  = r * W + c;
                w.self = f[w.idx];
                w.nbrs = '0;
                for (int k = 0; k < 8; k++) begin
                    int rr;
                    int cc;
                    rr = r + dr[k];
                    cc = c + dc[k];
                    if (rr >= 0 && rr < H && cc >= 0 && cc < W && f[rr * W + cc]) begin
                        w.nbrs[k] = 1'b1;
                        pop++;
                    end
                end
                w.nxt  = (pop == 3) || (w.self && pop == 2);
                w.last = (w.idx == N - 1);
                exp_q.push_back(w);
            end
        end
    endfunction

    // Called aligned to posedge+1; leaves inputs idle at posedge+1.
    task automatic send_frame(input logic [N-1:0] f, input int n, input bit gaps);
        for (int i = 0; i < n; i++) begin
            int b;
            bit ok;
            if (gaps && $urandom_range(0, 2) == 0) begin
                bus.in_valid = 1'b0;
                repeat ($urandom_range(1, 2)) @(posedge clk);
                #1;
            end
            bus.in_valid = 1'b1;
            bus.in_cell  = f[i];
            b  = 0;
            ok = 1'b0;
            while (b < 300) begin
                @(negedge clk);
                if (bus.in_ready) begin
                    ok = 1'b1;
                    break;
                end
                b++;
            end
            @(posedge clk);
            #1;
            if (!ok) begin
                check("in_ready_timeout", 0, 1);
                bus.in_valid = 1'b0;
                return;
            end
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int b;
        b = 0;
        while ((exp_q.size() != 0 || bus.out_valid) && b < 3000) begin
            @(negedge clk);
            b++;
        end
        check("drain_pending_windows", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_win(input int target);
        int b;
        b = 0;
        while (tot_win < target && b < 500) begin
            @(negedge clk);
            b++;
        end
        if (tot_win < target) check("stall_wait_timeout", tot_win, target);
    endtask

    task automatic check_reset_outputs();
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_self", bus.out_self, 0);
        check("rst_out_neighbors", bus.out_neighbors, 0);
        check("rst_out_last", bus.out_last, 0);
        check("rst_in_ready", bus.in_ready, 1);
`ifdef LIFE_NEXT_EN
        check("rst_out_next", bus.out_next, 0);
`endif
    endtask

    task automatic check_single_literals();
        logic [7:0] lit[N] = '{8'h80, 8'h40, 8'h20, 8'h00,
                               8'h10, 8'h00, 8'h08, 8'h00,
                               8'h04, 8'h02, 8'h01, 8'h00,
                               8'h00, 8'h00, 8'h00, 8'h00};
        for (int i = 0; i < N; i++) begin
            check($sformatf("single_nbrs[%0d]", i), cap_nbrs[i], lit[i]);
            check($sformatf("single_self[%0d]", i), cap_self[i], (i == 5) ? 1 : 0);
        end
    endtask

    // Drives out_ready: scripted stalls take priority over the current mode.
    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (stall_cnt > 0) begin
                bus.out_ready = 1'b0;
                stall_cnt--;
            end else if (ready_mode == 1) begin
                bus.out_ready = ($urandom_range(0, 3) != 0);
            end else begin
                bus.out_ready = 1'b1;
            end
        end
    end

    // Single compare process, sampling on the falling edge.
    always @(negedge clk) begin
        cyc++;
        if (fire_pend) acc_total++;
        fire_pend = bus.in_valid && bus.in_ready && !rst;
        if (rst || !chk_en) begin
            prev_stall = 1'b0;
        end else begin
            if (t_arm && bus.out_valid) begin
                first_acc = acc_total;
                first_cyc = cyc;
                t_arm     = 1'b0;
            end
            if (prev_stall) begin
                check("hold_valid", bus.out_valid, 1);
                check("hold_self", bus.out_self, held_self);
                check("hold_neighbors", bus.out_neighbors, held_nbrs);
                check("hold_last", bus.out_last, held_last);
            end
            if (bus.out_valid && !bus.out_ready) check("stall_in_ready", bus.in_ready, 0);
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_window", 1, 0);
                end else begin
                    win_t e;
                    e = exp_q.pop_front();
                    check($sformatf("self[%0d]", e.idx), bus.out_self, e.self);
                    check($sformatf("neighbors[%0d]", e.idx), bus.out_neighbors, e.nbrs);
                    check($sformatf("last[%0d]", e.idx), bus.out_last, e.last);
                    cap_self[e.idx] = bus.out_self;
                    cap_nbrs[e.idx] = bus.out_neighbors;
`ifdef LIFE_NEXT_EN
                    check($sformatf("next[%0d]", e.idx), bus.out_next, e.nxt);
                    cap_next[e.idx] = bus.out_next;
`else
                    cap_next[e.idx] = e.nxt;
`endif
                    tot_win++;
                    if (bus.out_last) last_cyc = cyc;
                end
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            held_self  = bus.out_self;
            held_nbrs  = bus.out_neighbors;
            held_last  = bus.out_last;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [N-1:0] f1;
        logic [N-1:0] f2;
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_cell  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs();
        @(posedge clk);
        #1;
        rst = 1'b0;

        // All zeros, full throughput: first window after the 6th accept, no bubbles
        acc_total = 0;
        t_arm     = 1'b1;
        model_frame(16'h0000);
        send_frame(16'h0000, N, 1'b0);
        wait_idle();
        check("first_valid_after_accepts", first_acc, W + 2);
        check("window_burst_span", last_cyc - first_cyc, N - 1);

        // Single live cell at (1,1)
        model_frame(16'h0020);
        send_frame(16'h0020, N, 1'b0);
        wait_idle();
        check_single_literals();

        // All ones
        model_frame(16'hFFFF);
        send_frame(16'hFFFF, N, 1'b0);
        wait_idle();
        check("ones_nbrs_0_0", cap_nbrs[0], 8'hD0);
        check("ones_nbrs_0_1", cap_nbrs[1], 8'hF8);
        check("ones_nbrs_3_3", cap_nbrs[15], 8'h0B);
        check("ones_nbrs_1_1", cap_nbrs[5], 8'hFF);

        // Back-to-back frames with stalls mid-RUN and mid-DRAIN of each
        f1      = N'($urandom());
        f2      = N'($urandom());
        tot_win = 0;
        model_frame(f1);
        model_frame(f2);
        fork
            begin
                send_frame(f1, N, 1'b0);
                send_frame(f2, N, 1'b0);
            end
            begin
                wait_win(3);
                stall_cnt = 5;
                wait_win(13);
                stall_cnt = 5;
                wait_win(N + 3);
                stall_cnt = 5;
                wait_win(N + 13);
                stall_cnt = 5;
            end
        join
        wait_idle();
        check("b2b_window_count", tot_win, 2 * N);

        // Reset after 7 accepts, then a clean single-cell frame
        chk_en = 1'b0;
        send_frame(16'h0020, 7, 1'b0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs();
        @(posedge clk);
        #1;
        rst    = 1'b0;
        exp_q.delete();
        chk_en = 1'b1;
        for (int i = 0; i < N; i++) cap_nbrs[i] = 8'hEE;
        model_frame(16'h0020);
        send_frame(16'h0020, N, 1'b0);
        wait_idle();
        check_single_literals();

        // Horizontal blinker across (1,0),(1,1),(1,2)
        model_frame(16'h0070);
        send_frame(16'h0070, N, 1'b0);
        wait_idle();
`ifdef LIFE_NEXT_EN
        for (int i = 0; i < N; i++) begin
            check($sformatf("blinker_next[%0d]", i), cap_next[i],
                  (i == 1 || i == 5 || i == 9) ? 1 : 0);
        end
`endif

        // Random frames, random input gaps and random back-pressure
        ready_mode = 1;
        for (int k = 0; k < 6; k++) begin
            f1 = N'($urandom());
            model_frame(f1);
            send_frame(f1, N, 1'b1);
        end
        wait_idle();
        ready_mode = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
